// File: rtl/gates4_pkg.sv
// Shared types and sizing for the gates_4 reduction unit.
package gates4_pkg;

  localparam int GATES4_W = 4;

  typedef struct packed {
    logic and_r;
    logic or_r;
    logic xor_r;
  } gates4_res_t;

endpackage

// File: rtl/gates_4_if.sv
// Operand/result bundle for gates_4: master drives x/in_valid, slave returns the reductions.
interface gates_4_if #(
  parameter int WIDTH = 4
) ();

  logic [WIDTH-1:0] x;
  logic             in_valid;
  logic             and4_;
  logic             or4_;
  logic             xor4_;
  logic             out_valid;

  modport master (
    output x, in_valid,
    input  and4_, or4_, xor4_, out_valid
  );

  modport slave (
    input  x, in_valid,
    output and4_, or4_, xor4_, out_valid
  );

endinterface

// File: rtl/gates4_reduce.sv
// Purely combinational AND/OR/XOR reductions of the operand vector.
module gates4_reduce
  import gates4_pkg::*;
#(
  parameter int WIDTH = GATES4_W
) (
  input  logic [WIDTH-1:0] x,
  output logic             and_r,
  output logic             or_r,
  output logic             xor_r
);

  assign and_r = &x;
  assign or_r  = |x;
  assign xor_r = ^x;

endmodule

// File: rtl/gates_4.sv
// Registered four-input reduction unit: one result per valid input, 1-cycle latency.
module gates_4
  import gates4_pkg::*;
#(
  parameter int WIDTH = GATES4_W
) (
  input  logic       clk,
  input  logic       rst_n,
  gates_4_if.slave   bus
);

  gates4_res_t res_p0;
  gates4_res_t res_p1;
  logic        vld_p1;

  gates4_reduce #(
    .WIDTH (WIDTH)
  ) u_reduce (
    .x     (bus.x),
    .and_r (res_p0.and_r),
    .or_r  (res_p0.or_r),
    .xor_r (res_p0.xor_r)
  );

  // p0 -> p1: capture on valid, hold otherwise; reset clears data too so LEDs go dark at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_p1 <= '0;
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= bus.in_valid;
      if (bus.in_valid) begin
        res_p1 <= res_p0;
      end
    end
  end

  assign bus.and4_     = res_p1.and_r;
  assign bus.or4_      = res_p1.or_r;
  assign bus.xor4_     = res_p1.xor_r;
  assign bus.out_valid = vld_p1;

endmodule

// File: tb/tb_gates_4.sv
// Scoreboard bench for gates_4: stimulus pushes expected outputs, a negedge monitor pops and compares.
module tb_gates_4;
  import gates4_pkg::*;

  typedef struct packed {
    logic       vld;
    logic [2:0] res;   // {and, or, xor}
  } exp_t;

  logic  clk = 1'b0;
  logic  rst_n;
  int    n_checks = 0;
  int    n_fail   = 0;
  exp_t  sb_q[$];
  logic [2:0] m_res;
  string phase = "init";

  gates_4_if #(.WIDTH(GATES4_W)) bus ();

  gates_4 #(.WIDTH(GATES4_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s [%s]: got %b expected %b (vld,and,or,xor)", name, phase, act, exp);
    end
  endtask

  // Reference reduction written independently of the reduction operators
  function automatic logic [2:0] ref_red(input logic [3:0] v);
    logic a, o, p;
    a = (v == 4'hF);
    o = (v != 4'h0);
    p = ($countones(v) % 2) == 1;
    return {a, o, p};
  endfunction

  task automatic push(input logic vld, input logic [2:0] res);
    if (vld) m_res = res;
    sb_q.push_back(exp_t'{vld: vld, res: m_res});
  endtask

  task automatic drive(input logic vld, input logic [3:0] v, input logic [2:0] exp);
    @(negedge clk);
    #2;
    bus.x        = v;
    bus.in_valid = vld;
    push(vld, exp);
  endtask

  function automatic logic [3:0] outs();
    return {bus.out_valid, bus.and4_, bus.or4_, bus.xor4_};
  endfunction

  // Monitor: one scoreboard entry per post-edge cycle; with nothing pending out_valid must be low
  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check("sb_out", outs(), {e.vld, e.res});
    end else begin
      check("idle_vld", {3'b000, bus.out_valid}, 4'b0000);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n        = 1'b1;
    bus.x        = 4'b1111;
    bus.in_valid = 1'b1;
    m_res        = 3'b000;
    #1 rst_n = 1'b0;

    phase = "reset";
    repeat (3) @(negedge clk);
    #2;
    check("rst_hold", outs(), 4'b0000);
    rst_n = 1'b1;
    push(1'b1, 3'b110);

    phase = "directed";
    drive(1'b1, 4'b1010, 3'b010);
    drive(1'b1, 4'b0110, 3'b010);
    drive(1'b1, 4'b0011, 3'b010);
    drive(1'b1, 4'b1000, 3'b011);
    drive(1'b1, 4'b0001, 3'b011);
    drive(1'b1, 4'b0000, 3'b000);
    drive(1'b1, 4'b0111, 3'b011);

    phase = "exhaustive";
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 4'(i), ref_red(4'(i)));
    end

    phase = "hold";
    drive(1'b1, 4'b0001, 3'b011);
    drive(1'b0, 4'b1111, 3'b000);
    drive(1'b0, 4'b1111, 3'b000);

    phase = "midreset";
    drive(1'b1, 4'b0101, 3'b010);
    drive(1'b1, 4'b1011, 3'b011);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    sb_q.delete();
    m_res = 3'b000;
    #1;
    check("async_clr", outs(), 4'b0000);
    @(negedge clk);
    @(negedge clk);
    #2;
    check("rst_noload", outs(), 4'b0000);
    bus.in_valid = 1'b0;
    rst_n        = 1'b1;
    drive(1'b1, 4'b1110, 3'b011);

    phase = "drain";
    drive(1'b0, 4'b0000, 3'b000);
    drive(1'b0, 4'b0000, 3'b000);
    for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(negedge clk);
    #1;
    check("drain_empty", 4'(sb_q.size()), 4'b0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
